// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider (restoring, radix-2, one quotient bit per cycle).
// Number format: SIGN | Q_M integer magnitude bits | Q_N fractional bits.
//
// Ports:
//   clk_in          - clock, all state on rising edge
//   rst_n_in        - asynchronous active-low reset
//   valid_in        - operands valid (ignored while ready_out = 0)
//   ready_out       - divider idle, can accept operands
//   a_in            - dividend, sign-magnitude
//   b_in            - divisor, sign-magnitude
//   valid_out       - result valid, held until taken
//   ready_in        - downstream accepts result
//   y_out           - quotient, sign-magnitude
//   div_by_zero_out - divisor magnitude was zero (qualified by valid_out)
//   saturated_out   - quotient magnitude clipped (qualified by valid_out)
module fixed_point_divider #(
  parameter int unsigned SIGN = 1,
  parameter int unsigned Q_M  = 15,
  parameter int unsigned Q_N  = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [SIGN+Q_M+Q_N-1:0]   a_in,
  input  logic [SIGN+Q_M+Q_N-1:0]   b_in,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [SIGN+Q_M+Q_N-1:0]   y_out,
  output logic                      div_by_zero_out,
  output logic                      saturated_out
);

  localparam int unsigned W      = SIGN + Q_M + Q_N;
  localparam int unsigned MW     = W - 1;
  localparam int unsigned N_ITER = MW + Q_N;
  localparam int unsigned CNT_W  = $clog2(N_ITER);

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StDivZero,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic              sign_q;
  logic [MW-1:0]     b_mag_q;
  logic [N_ITER-1:0] dvd_q;
  logic [MW:0]       rem_q;
  logic [N_ITER-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [W-1:0]      y_q;
  logic              dbz_q;
  logic              sat_q;

  // One restoring step. The shifted remainder is kept one bit wider than rem_q so the
  // trial subtraction can never lose a carry, and an extra top bit serves as the borrow.
  logic [MW+1:0]     rem_shift;
  logic [MW+2:0]     trial;
  logic              q_bit;
  logic [MW:0]       rem_next;
  logic [N_ITER-1:0] quo_next;
  logic              overflow;
  logic [MW-1:0]     mag_final;
  logic              sign_final;

  always_comb begin
    rem_shift  = {rem_q, dvd_q[N_ITER-1]};
    trial      = {1'b0, rem_shift} - {3'b000, b_mag_q};
    q_bit      = ~trial[MW+2];
    rem_next   = q_bit ? trial[MW:0] : rem_shift[MW:0];
    quo_next   = {quo_q[N_ITER-2:0], q_bit};
    // Any quotient bit at or above 2^MW means the magnitude does not fit.
    overflow   = |quo_next[N_ITER-1:MW];
    mag_final  = overflow ? {MW{1'b1}} : quo_next[MW-1:0];
    // Never emit negative zero.
    sign_final = sign_q & (|mag_final);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_out = 1'b1;
        if (valid_in) begin
          state_d = (b_in[MW-1:0] == '0) ? StDivZero : StDivide;
        end
      end
      StDivide: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDivZero: begin
        state_d = StDone;
      end
      StDone: begin
        valid_out = 1'b1;
        if (ready_in) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sign_q  <= 1'b0;
      b_mag_q <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      dbz_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_in) begin
            sign_q  <= a_in[W-1] ^ b_in[W-1];
            b_mag_q <= b_in[MW-1:0];
            dvd_q   <= {a_in[MW-1:0], {Q_N{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= CNT_W'(N_ITER - 1);
          end
        end
        StDivide: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            y_q   <= {sign_final, mag_final};
            dbz_q <= 1'b0;
            sat_q <= overflow;
          end
        end
        StDivZero: begin
          y_q   <= {sign_q, {MW{1'b1}}};
          dbz_q <= 1'b1;
          sat_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign y_out           = y_q;
  assign div_by_zero_out = dbz_q;
  assign saturated_out   = sat_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider (default Q15.16 sign-magnitude format).
module tb_fixed_point_divider;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] a_in     = '0;
  logic [31:0] b_in     = '0;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] y_out;
  logic        div_by_zero_out;
  logic        saturated_out;

  fixed_point_divider dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .a_in           (a_in),
    .b_in           (b_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .y_out          (y_out),
    .div_by_zero_out(div_by_zero_out),
    .saturated_out  (saturated_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        dbz;
    logic        sat;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: quotient from plain integer arithmetic on magnitudes.
  // Returns {dbz, sat, y}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] q;
    logic [30:0] mag;
    logic        s;
    logic        sat;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {1'b1, 1'b0, s, 31'h7fffffff};
    q = ({33'd0, a[30:0]} << 16) / {33'd0, b[30:0]};
    sat = (q >= 64'h8000_0000);
    mag = sat ? 31'h7fffffff : q[30:0];
    if (mag == 31'd0) s = 1'b0;
    return {1'b0, sat, s, mag};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_in);
    check1("ready_before_accept", ready_out, 1'b1);
    valid_in = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    // Scramble operands: only the accept edge may matter.
    a_in     = $urandom;
    b_in     = $urandom;
  endtask

  task automatic wait_result(output logic [31:0] y, output logic dz, output logic st,
                             output int lat);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    if (!valid_out) check1("result_timeout", valid_out, 1'b1);
    y  = y_out;
    dz = div_by_zero_out;
    st = saturated_out;
  endtask

  task automatic take_result(input int hold, input logic [31:0] y_saved);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in);
      #1;
      check1("bp_valid", valid_out, 1'b1);
      check32("bp_y", y_out, y_saved);
    end
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
    check1("post_xfer_valid", valid_out, 1'b0);
    check1("post_xfer_ready", ready_out, 1'b1);
  endtask

  initial begin
    logic [31:0] y;
    logic        dz;
    logic        st;
    int          lat;
    logic [33:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 47, 5};
    vecs[1] = '{32'h8006_0000, 32'h0004_0000, 32'h8001_8000, 1'b0, 1'b0, 47, 0};
    vecs[2] = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 47, 1};
    vecs[3] = '{32'h8001_0000, 32'h8000_0000, 32'h7fff_ffff, 1'b1, 1'b0, 1,  2};
    vecs[4] = '{32'h4000_0000, 32'h0000_0001, 32'h7fff_ffff, 1'b0, 1'b1, 47, 0};
    vecs[5] = '{32'h8000_0001, 32'h7fff_ffff, 32'h0000_0000, 1'b0, 1'b0, 47, 0};
    vecs[6] = '{32'h0000_0000, 32'h8000_0000, 32'hffff_ffff, 1'b1, 1'b0, 1,  0};
    vecs[7] = '{32'h8000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 1'b0, 47, 0};

    // Reset state
    #12;
    check1("rst_ready", ready_out, 1'b1);
    check1("rst_valid", valid_out, 1'b0);
    check32("rst_y", y_out, 32'h0);
    check1("rst_dbz", div_by_zero_out, 1'b0);
    check1("rst_sat", saturated_out, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(y, dz, st, lat);
      check32("vec_y", y, vecs[i].y);
      check1("vec_dbz", dz, vecs[i].dbz);
      check1("vec_sat", st, vecs[i].sat);
      check32("vec_latency", 32'(lat), 32'(vecs[i].lat));
      take_result(vecs[i].hold, vecs[i].y);
    end

    // valid_in pulsed with new operands during DIVIDE must be ignored
    start_op(32'h0003_0000, 32'h0002_0000);
    repeat (10) @(posedge clk_in);
    @(negedge clk_in);
    check1("busy_ready", ready_out, 1'b0);
    valid_in = 1'b1;
    a_in     = 32'h0010_0000;
    b_in     = 32'h0000_0001;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    wait_result(y, dz, st, lat);
    check32("ignore_y", y, 32'h0001_8000);
    check1("ignore_sat", st, 1'b0);
    take_result(0, y);

    // Asynchronous reset mid-DIVIDE
    start_op(32'h7fff_0000, 32'h0000_0003);
    repeat (20) @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check1("midrst_ready", ready_out, 1'b1);
    check1("midrst_valid", valid_out, 1'b0);
    check32("midrst_y", y_out, 32'h0);
    check1("midrst_dbz", div_by_zero_out, 1'b0);
    check1("midrst_sat", saturated_out, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_result(y, dz, st, lat);
    check32("after_rst_y", y, 32'h0001_0000);
    check32("after_rst_latency", 32'(lat), 32'd47);
    take_result(0, y);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      ra[30:0] = ra[30:0] >> $urandom_range(0, 30);
      rb = $urandom;
      rb[30:0] = rb[30:0] >> $urandom_range(0, 30);
      if ($urandom_range(0, 9) == 0) rb[30:0] = 31'd0;
      exp = model(ra, rb);
      start_op(ra, rb);
      wait_result(y, dz, st, lat);
      check32("rand_y", y, exp[31:0]);
      check1("rand_sat", st, exp[32]);
      check1("rand_dbz", dz, exp[33]);
      check32("rand_latency", 32'(lat), exp[33] ? 32'd1 : 32'd47);
      take_result($urandom_range(0, 3), exp[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential sign-magnitude fixed-point divider, the inverse operation of `fixed_point_multiplier`, in the same SIGN/Q_M/Q_N number format. It computes `y = a / b` with a restoring radix-2 algorithm, one quotient bit per cycle. It uses valid/ready handshakes on both input and output. It sits in the perceptron datapath wherever normalisation or averaging needs a true divide, such as learning-rate scaling or mean computation.

## Interface
- SIGN, 1, sign bit count (MSB; 1 = negative, magnitude in remaining bits)
- Q_M, 15, integer magnitude bits
- Q_N, 16, fractional bits; W = SIGN+Q_M+Q_N, MW = W-1, N_ITER = MW+Q_N
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- valid_in  input  1  operands valid
- ready_out  output  1  divider idle, can accept operands
- a_in  input  W  dividend, sign-magnitude
- b_in  input  W  divisor, sign-magnitude
- valid_out  output  1  result valid, held until taken
- ready_in  input  1  downstream accepts result
- y_out  output  W  quotient, sign-magnitude
- div_by_zero_out  output  1  divisor magnitude was 0; qualified by valid_out
- saturated_out  output  1  quotient magnitude clipped; qualified by valid_out

## Operation
- Quotient magnitude: Q = floor((|a| << Q_N) / |b|), computed over N_ITER bits. Truncate toward zero; no rounding.
- Saturation: if Q ≥ 2^MW, magnitude = 2^MW-1 (all ones) and saturated_out = 1.
- Sign: y_out[W-1] = a_in[W-1] ^ b_in[W-1]. It is forced to 0 when the final magnitude is 0, so the divider never outputs negative zero.
- Divide by zero (|b| = 0): magnitude = all ones, sign = a^b, div_by_zero_out = 1, saturated_out = 0. This includes a = ±0.
- Operands with sign set and zero magnitude are valid inputs equal to zero.
- State machine:
  - IDLE: ready_out = 1.
    - On valid_in: latch sign, |a|, |b|.
    - If |b| = 0, go to DONE with the divide-by-zero result.
    - Otherwise load the dividend shift register (|a| << Q_N, N_ITER bits), clear the remainder (MW+1 bits), set the iteration counter to N_ITER-1, and go to DIVIDE.
  - DIVIDE: each cycle:
    - Shift the next dividend MSB into the remainder.
    - Trial subtract |b|.
    - If the result is non-negative, keep the difference and the quotient bit is 1; otherwise restore and the quotient bit is 0.
    - When the counter reaches 0, apply saturation and sign rules, register y_out and flags, and go to DONE.
  - DONE: valid_out = 1, ready_out = 0. y_out and flags are held stable. On ready_in, go to IDLE.
- Handshake rules:
  - valid_in is ignored while ready_out = 0.
  - Operands are sampled only on the accepting edge, so later changes to a_in/b_in have no effect.
- Reset mid-operation aborts immediately. No result is produced for the in-flight operation.

## Timing
- Reset values: ready_out = 1, valid_out = 0, y_out = 0, div_by_zero_out = 0, saturated_out = 0. State is IDLE.
- Accept edge E0 is a rising edge with valid_in & ready_out.
- Normal latency: valid_out rises after edge E(N_ITER), which is E47 with default parameters. Iterations occur at E1..E47.
- Divide-by-zero latency: valid_out rises after E1.
- Result transfer occurs at an edge with valid_out & ready_in. valid_out deasserts and ready_out reasserts after that edge.
- The next accept is possible at the following edge, giving a minimum issue interval of N_ITER+2 cycles.
- No accept happens in the same cycle as result transfer.
- Backpressure: valid_out, y_out and flags are unchanged for any number of cycles that ready_in is held low.
- y_out holds the last result after transfer until the next result is registered. Its value is meaningful only while valid_out = 1.

## Test plan
- 3.0/2.0: a=0x00030000, b=0x00020000 → y=0x00018000, flags 0. valid_out rises 47 cycles after accept.
- -6.0/4.0 and 1.0/3.0:
  - a=0x80060000, b=0x00040000 → y=0x80018000.
  - a=0x00010000, b=0x00030000 → y=0x00005555 (truncated).
- Divide by zero: a=0x80010000, b=0x80000000 → y=0x7FFFFFFF, div_by_zero_out=1, valid_out one cycle after accept.
- Overflow and negative zero:
  - a=0x40000000, b=0x00000001 → y=0x7FFFFFFF, saturated_out=1.
  - a=0x80000001, b=0x7FFFFFFF → y=0x00000000 with sign cleared.
- Handshake:
  - Hold ready_in low 5 cycles in DONE → y_out and valid_out stable throughout.
  - Pulse valid_in with new operands during DIVIDE → ignored, result unchanged.
- Reset: assert rst_n_in low mid-DIVIDE → outputs at reset values immediately (asynchronously). After release, a fresh 1.0/1.0 returns 0x00010000.
